// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - parametrised sprite/page block-copy DMA engine
//
// Purpose: a CPU write to TRIG_ADDR starts a copy of 2^LEN_W words from
// CPU address space {page, index} into a destination port. While the copy
// runs the CPU is held off the bus and the engine drives the memory address.
//
// Ports:
//   i_clk       system clock, all logic on posedge
//   i_reset     synchronous active-high reset
//   i_ce        CPU-cycle enable pulse (one clk wide, >= 2 clk apart)
//   i_wr_en     CPU write strobe
//   i_wr_addr   CPU write address
//   i_wr_data   CPU write data (source page on a trigger write)
//   o_busy      transfer in progress; CPU ready = !o_busy
//   o_rd_addr   source address to system memory
//   i_rd_data   memory read data, valid 1 clk after o_rd_addr
//   o_dst_we    destination write strobe, one clk wide
//   o_dst_addr  destination index
//   o_dst_data  destination write data
//   o_done      one-clk pulse at transfer completion
module oam_dma_engine #(
   parameter int              AW        = 16,
   parameter int              DW        = 8,
   parameter int              LEN_W     = 8,
   parameter logic [AW-1:0]   TRIG_ADDR = 16'h4014,
   parameter bit              ALIGN     = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_ce,
   input  logic             i_wr_en,
   input  logic [AW-1:0]    i_wr_addr,
   input  logic [DW-1:0]    i_wr_data,
   output logic             o_busy,
   output logic [AW-1:0]    o_rd_addr,
   input  logic [DW-1:0]    i_rd_data,
   output logic             o_dst_we,
   output logic [LEN_W-1:0] o_dst_addr,
   output logic [DW-1:0]    o_dst_data,
   output logic             o_done
);

   localparam int PW = AW - LEN_W;
   localparam logic [LEN_W-1:0] LAST_IDX = '1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGNW,
      S_READ,
      S_WRITE
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [PW-1:0]    r_page, w_page_nxt, w_page_in;
   logic [LEN_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_odd;
   logic             r_dst_we, w_dst_we_nxt;
   logic             r_done, w_done_nxt;
   logic [LEN_W-1:0] r_dst_addr;
   logic [DW-1:0]    r_dst_data;
   logic             w_trigger;

   // Page register is AW-LEN_W bits wide; the write data is truncated or
   // zero-extended to fit, so the source never leaves one 2^LEN_W page.
   generate
      if (DW >= PW) begin : g_page_trunc
         assign w_page_in = i_wr_data[PW-1:0];
      end else begin : g_page_zext
         assign w_page_in = {{(PW-DW){1'b0}}, i_wr_data};
      end
   endgenerate

   assign w_trigger = i_wr_en && (i_wr_addr == TRIG_ADDR);

   always_comb begin
      w_state_nxt  = r_state;
      w_page_nxt   = r_page;
      w_cnt_nxt    = r_cnt;
      w_dst_we_nxt = 1'b0;
      w_done_nxt   = 1'b0;
      case (r_state)
         // Trigger is taken regardless of i_ce; a coincident ce only toggles odd.
         S_IDLE: begin
            if (w_trigger) begin
               w_state_nxt = S_HALT;
               w_page_nxt  = w_page_in;
               w_cnt_nxt   = '0;
            end
         end
         // r_odd here is the parity of the HALT tick itself (before its toggle).
         S_HALT: begin
            if (i_ce) begin
               w_state_nxt = (ALIGN && r_odd) ? S_ALIGNW : S_READ;
            end
         end
         S_ALIGNW: begin
            if (i_ce) begin
               w_state_nxt = S_READ;
            end
         end
         S_READ: begin
            if (i_ce) begin
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            if (i_ce) begin
               w_dst_we_nxt = 1'b1;
               if (r_cnt == LAST_IDX) begin
                  w_state_nxt = S_IDLE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt   = r_cnt + 1'b1;
                  w_state_nxt = S_READ;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_page     <= '0;
         r_cnt      <= '0;
         r_odd      <= 1'b0;
         r_dst_we   <= 1'b0;
         r_done     <= 1'b0;
         r_dst_addr <= '0;
         r_dst_data <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_page   <= w_page_nxt;
         r_cnt    <= w_cnt_nxt;
         r_dst_we <= w_dst_we_nxt;
         r_done   <= w_done_nxt;
         if (i_ce) begin
            r_odd <= ~r_odd;
         end
         // Destination index/data hold their last value between strobes.
         if (w_dst_we_nxt) begin
            r_dst_addr <= r_cnt;
            r_dst_data <= i_rd_data;
         end
      end
   end

   assign o_busy     = (r_state != S_IDLE);
   assign o_rd_addr  = (r_state == S_IDLE) ? '0 : {r_page, r_cnt};
   assign o_dst_we   = r_dst_we;
   assign o_dst_addr = r_dst_addr;
   assign o_dst_data = r_dst_data;
   assign o_done     = r_done;

endmodule

// File: tb/tb_oam_dma_engine.sv
// tb/tb_oam_dma_engine.sv - scoreboard bench for oam_dma_engine (three configurations)
module tb_oam_dma_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        i_reset, i_ce, i_wr_en;
   logic [15:0] i_wr_addr, i_wr_data;
   logic [15:0] mem [0:65535];

   logic        a_busy, a_we, a_done;
   logic [15:0] a_rd_addr;
   logic [7:0]  a_rd_data, a_dst_addr, a_dst_data;
   logic        b_busy, b_we, b_done;
   logic [15:0] b_rd_addr;
   logic [7:0]  b_rd_data, b_dst_addr, b_dst_data;
   logic        c_busy, c_we, c_done;
   logic [15:0] c_rd_addr, c_rd_data, c_dst_data;
   logic [3:0]  c_dst_addr;

   oam_dma_engine #(.ALIGN(1'b1)) u_a (
      .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_wr_en(i_wr_en),
      .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data[7:0]), .o_busy(a_busy),
      .o_rd_addr(a_rd_addr), .i_rd_data(a_rd_data), .o_dst_we(a_we),
      .o_dst_addr(a_dst_addr), .o_dst_data(a_dst_data), .o_done(a_done));

   oam_dma_engine #(.ALIGN(1'b0)) u_b (
      .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_wr_en(i_wr_en),
      .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data[7:0]), .o_busy(b_busy),
      .o_rd_addr(b_rd_addr), .i_rd_data(b_rd_data), .o_dst_we(b_we),
      .o_dst_addr(b_dst_addr), .o_dst_data(b_dst_data), .o_done(b_done));

   oam_dma_engine #(.AW(16), .DW(16), .LEN_W(4), .ALIGN(1'b1)) u_c (
      .i_clk(clk), .i_reset(i_reset), .i_ce(i_ce), .i_wr_en(i_wr_en),
      .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .o_busy(c_busy),
      .o_rd_addr(c_rd_addr), .i_rd_data(c_rd_data), .o_dst_we(c_we),
      .o_dst_addr(c_dst_addr), .o_dst_data(c_dst_data), .o_done(c_done));

   // system memory: data valid one clk after the address
   always @(posedge clk) begin
      a_rd_data <= mem[a_rd_addr][7:0];
      b_rd_data <= mem[b_rd_addr][7:0];
      c_rd_data <= mem[c_rd_addr];
   end

   logic        m_busy [3];
   logic        m_we   [3];
   logic        m_done [3];
   logic [15:0] m_rdad [3];
   logic [15:0] m_dadr [3];
   logic [15:0] m_ddat [3];
   always_comb begin
      m_busy[0] = a_busy; m_we[0] = a_we; m_done[0] = a_done;
      m_rdad[0] = a_rd_addr; m_dadr[0] = {8'h00, a_dst_addr}; m_ddat[0] = {8'h00, a_dst_data};
      m_busy[1] = b_busy; m_we[1] = b_we; m_done[1] = b_done;
      m_rdad[1] = b_rd_addr; m_dadr[1] = {8'h00, b_dst_addr}; m_ddat[1] = {8'h00, b_dst_data};
      m_busy[2] = c_busy; m_we[2] = c_we; m_done[2] = c_done;
      m_rdad[2] = c_rd_addr; m_dadr[2] = {12'h000, c_dst_addr}; m_ddat[2] = c_dst_data;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input int d, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
      end
   endtask

   // ---------------- reference model (per configuration) ----------------
   function automatic int f_len(input int d);
      return (d == 2) ? 16 : 256;
   endfunction
   function automatic int f_lb(input int d);
      return (d == 2) ? 4 : 8;
   endfunction
   function automatic bit f_align(input int d);
      return (d != 1);
   endfunction

   bit          mo_active [3];
   bit          mo_odd    [3];
   bit          mo_al     [3];
   bit          mo_busy_cur [3];
   int          mo_tick   [3];
   int          mo_exp    [3];
   int          mo_page   [3];
   int          mo_bytes  [3];
   logic [31:0] wq [3][512];
   int          wq_h [3];
   int          wq_t [3];
   int          dq [3][8];
   int          dq_h [3];
   int          dq_t [3];
   int          phase;

   task automatic push_write(input int d, input int idx);
      int addr;
      logic [15:0] data;
      addr = ((mo_page[d] << f_lb(d)) | idx) & 16'hFFFF;
      data = (d == 2) ? mem[addr] : {8'h00, mem[addr][7:0]};
      wq[d][wq_t[d] % 512] = {idx[15:0], data};
      wq_t[d]++;
      mo_bytes[d]++;
   endtask

   // Advances the model across the posedge that samples the current inputs.
   task automatic model_update();
      for (int d = 0; d < 3; d++) begin
         if (i_reset) begin
            mo_active[d] = 1'b0;
            mo_odd[d]    = 1'b0;
         end else begin
            if (mo_active[d]) begin
               if (i_ce) begin
                  int k;
                  if (mo_tick[d] == 0) begin
                     mo_al[d]  = f_align(d) && mo_odd[d];
                     mo_exp[d] = 1 + int'(mo_al[d]) + 2 * f_len(d);
                  end
                  mo_tick[d]++;
                  // ticks after the halt/align prefix alternate read, write
                  k = mo_tick[d] - 1 - int'(mo_al[d]);
                  if (k > 0 && (k % 2) == 0) push_write(d, k / 2 - 1);
                  if (mo_tick[d] == mo_exp[d]) begin
                     mo_active[d] = 1'b0;
                     dq[d][dq_t[d] % 8] = mo_exp[d];
                     dq_t[d]++;
                  end
               end
            end else if (i_wr_en && i_wr_addr == 16'h4014) begin
               mo_active[d] = 1'b1;
               mo_tick[d]   = 0;
               mo_bytes[d]  = 0;
               mo_page[d]   = (d == 2) ? int'(i_wr_data[11:0]) : int'(i_wr_data[7:0]);
            end
            if (i_ce) mo_odd[d] = !mo_odd[d];
         end
      end
   endtask

   // ---------------- stimulus ----------------
   task automatic step(input bit rst, input bit we, input logic [15:0] addr, input logic [15:0] data);
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) mo_busy_cur[d] = mo_active[d];
      phase     = (phase + 1) % 4;
      i_ce      = (phase == 0);
      i_reset   = rst;
      i_wr_en   = we;
      i_wr_addr = addr;
      i_wr_data = data;
      model_update();
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   // want_odd selects the parity of the HALT tick (next ce after the trigger)
   task automatic trigger(input bit want_odd, input logic [15:0] data);
      int n;
      n = 0;
      while (((mo_odd[0] ^ (phase == 3)) != want_odd) && n < 8) begin
         idle_step();
         n++;
      end
      step(1'b0, 1'b1, 16'h4014, data);
   endtask

   task automatic run_idle(input int budget);
      int n;
      n = 0;
      while ((mo_active[0] || mo_active[1] || mo_active[2]) && n < budget) begin
         idle_step();
         n++;
      end
      check("idle_within_budget", 0, int'(n >= budget), 0);
      repeat (4) idle_step();
   endtask

   task automatic wait_bytes(input int d, input int nb);
      int n;
      n = 0;
      while (mo_bytes[d] < nb && n < 3000) begin
         idle_step();
         n++;
      end
      check("byte_wait_budget", d, int'(n >= 3000), 0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      bit pb [3];
      bit pm [3];
      int ticks [3];
      logic [31:0] e;
      for (int d = 0; d < 3; d++) begin pb[d] = 0; pm[d] = 0; ticks[d] = 0; end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 3; d++) begin
            if (m_we[d] === 1'b1) begin
               if (wq_h[d] == wq_t[d]) begin
                  n_vec++; n_bad++;
                  $display("FAIL dst_we_unexpected dut%0d: got pulse expected none at %0t", d, $time);
               end else begin
                  e = wq[d][wq_h[d] % 512];
                  wq_h[d]++;
                  check("dst_addr", d, int'(m_dadr[d]), int'(e[31:16]));
                  check("dst_data", d, int'(m_ddat[d]), int'(e[15:0]));
               end
            end
            if (m_done[d] === 1'b1) begin
               if (dq_h[d] == dq_t[d]) begin
                  n_vec++; n_bad++;
                  $display("FAIL done_unexpected dut%0d: got pulse expected none at %0t", d, $time);
               end else begin
                  check("done_ticks", d, ticks[d], dq[d][dq_h[d] % 8]);
                  dq_h[d]++;
               end
               check("busy_at_done", d, int'(m_busy[d]), 0);
               check("rd_addr_idle", d, int'(m_rdad[d]), 0);
               ticks[d] = 0;
            end
            if (m_busy[d] != pb[d] || mo_busy_cur[d] != pm[d])
               check("busy_edge", d, int'(m_busy[d]), int'(mo_busy_cur[d]));
            pb[d] = m_busy[d];
            pm[d] = mo_busy_cur[d];
            if (i_reset) ticks[d] = 0;
            else if (m_busy[d] && i_ce) ticks[d]++;
         end
      end
   end

   // ---------------- test sequence ----------------
   initial begin
      i_reset = 1'b1; i_ce = 1'b0; i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
      phase = 0;
      for (int d = 0; d < 3; d++) begin
         mo_active[d] = 0; mo_odd[d] = 0; mo_busy_cur[d] = 0; mo_tick[d] = 0;
         mo_bytes[d] = 0; wq_h[d] = 0; wq_t[d] = 0; dq_h[d] = 0; dq_t[d] = 0;
      end
      for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
      for (int i = 0; i < 256; i++) mem[16'h0200 + i] = {8'($urandom), 8'(i) ^ 8'h5A};

      step(1'b1, 1'b0, 16'h0, 16'h0);
      step(1'b1, 1'b0, 16'h0, 16'h0);
      step(1'b0, 1'b0, 16'h0, 16'h0);
      for (int d = 0; d < 3; d++) begin
         check("rst_busy", d, int'(m_busy[d]), 0);
         check("rst_rd_addr", d, int'(m_rdad[d]), 0);
         check("rst_dst_we", d, int'(m_we[d]), 0);
         check("rst_dst_addr", d, int'(m_dadr[d]), 0);
         check("rst_dst_data", d, int'(m_ddat[d]), 0);
         check("rst_done", d, int'(m_done[d]), 0);
      end

      // writes that must not start a transfer
      step(1'b0, 1'b1, 16'h4015, 16'h0002);
      step(1'b0, 1'b0, 16'h4014, 16'h0002);
      repeat (12) idle_step();
      for (int d = 0; d < 3; d++) check("no_trigger_busy", d, int'(m_busy[d]), 0);

      // even and odd start parity
      trigger(1'b0, 16'h0002);
      run_idle(2400);
      trigger(1'b1, 16'h0002);
      run_idle(2400);

      // trigger coinciding with a ce tick in IDLE
      while (phase != 3) idle_step();
      step(1'b0, 1'b1, 16'h4014, 16'h0002);
      run_idle(2400);

      // second trigger mid-transfer is ignored by busy engines
      trigger(1'b0, 16'h0002);
      wait_bytes(0, 100);
      step(1'b0, 1'b1, 16'h4014, 16'h0003);
      run_idle(2400);

      // reset mid-transfer abandons the copy, then a fresh transfer completes
      trigger(1'b1, 16'h0002);
      wait_bytes(0, 37);
      step(1'b1, 1'b0, 16'h0, 16'h0);
      step(1'b0, 1'b0, 16'h0, 16'h0);
      for (int d = 0; d < 3; d++) begin
         check("midrst_busy", d, int'(m_busy[d]), 0);
         check("midrst_dst_we", d, int'(m_we[d]), 0);
         check("midrst_done", d, int'(m_done[d]), 0);
      end
      trigger(1'b0, 16'h0002);
      run_idle(2400);

      // top page: no carry out of the page for the 16-word engine
      trigger(1'b0, 16'h0FFF);
      run_idle(2400);

      // randomized pages and parity
      repeat (3) begin
         trigger(1'($urandom_range(1)), 16'($urandom) & 16'h0FFF);
         run_idle(2400);
      end

      for (int d = 0; d < 3; d++) begin
         check("writes_all_seen", d, wq_t[d] - wq_h[d], 0);
         check("dones_all_seen", d, dq_t[d] - dq_h[d], 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
